// File: rtl/lcd_backlight_fader.sv
// lcd_backlight_fader: ramps a PWM backlight drive linearly between off and MAX_LEVEL on a PIO on/off request.
module lcd_backlight_fader #(
    parameter int PWM_BITS    = 8,
    parameter int MAX_LEVEL   = 2**PWM_BITS-1,
    parameter int STEP_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                light_req,
    input  logic                fade_en,
    output logic                lcd_bl_pwm,
    output logic [PWM_BITS-1:0] level,
    output logic                busy,
    output logic                at_target
);
    localparam int PW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(MAX_LEVEL);
    localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] CNT_TOP = PWM_BITS'(2**PWM_BITS-2);
    localparam logic [PW-1:0] TC = PW'(STEP_CYCLES-1);
    typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} state_t;
    state_t state, state_nxt;
    logic light_q, tc;
    logic [PW-1:0] presc, presc_nxt;
    logic [PWM_BITS-1:0] level_nxt, target, pwm_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= OFF;
            light_q    <= 1'b0;
            level      <= '0;
            presc      <= '0;
            pwm_cnt    <= '0;
            lcd_bl_pwm <= 1'b0;
            at_target  <= 1'b1;
        end else begin
            state      <= state_nxt;
            light_q    <= light_req;
            level      <= level_nxt;
            presc      <= presc_nxt;
            pwm_cnt    <= pwm_cnt == CNT_TOP ? '0 : pwm_cnt + ONE;
            lcd_bl_pwm <= pwm_cnt < level;
            at_target  <= level_nxt == (light_req ? MAX : '0);
        end
    end
    // prescaler defaults to zero so every ramp entry, reversal and step restarts it
    always_comb begin
        target    = light_q ? MAX : '0;
        tc        = presc == TC;
        state_nxt = state;
        level_nxt = level;
        presc_nxt = '0;
        if (!fade_en) begin
            state_nxt = light_q ? ON : OFF;
            level_nxt = target;
        end else begin
            case (state)
                OFF: state_nxt = light_q ? RAMP_UP : OFF;
                ON:  state_nxt = light_q ? ON : RAMP_DOWN;
                RAMP_UP: begin
                    if (!light_q) state_nxt = RAMP_DOWN;
                    else if (level == MAX) state_nxt = ON;
                    else if (tc) begin
                        level_nxt = level + ONE;
                        state_nxt = (level + ONE) == MAX ? ON : RAMP_UP;
                    end else presc_nxt = presc + PW'(1);
                end
                RAMP_DOWN: begin
                    if (light_q) state_nxt = RAMP_UP;
                    else if (level == '0) state_nxt = OFF;
                    else if (tc) begin
                        level_nxt = level - ONE;
                        state_nxt = level == ONE ? OFF : RAMP_DOWN;
                    end else presc_nxt = presc + PW'(1);
                end
            endcase
        end
    end
    always_comb busy = state == RAMP_UP || state == RAMP_DOWN;
endmodule

// File: tb/tb_lcd_backlight_fader.sv
// tb_lcd_backlight_fader: scoreboard bench; stimulus queues expected outputs per cycle, a monitor pops and compares.
module tb_lcd_backlight_fader;
    logic clk = 1'b0, reset = 1'b1;
    logic light_a = 1'b0, fade_a = 1'b1, light_b = 1'b0, fade_b = 1'b0, light_c = 1'b0, fade_c = 1'b1;
    logic pwm_a, busy_a, at_a, pwm_b, busy_b, at_b, pwm_c, busy_c, at_c;
    logic [3:0] lvl_a, lvl_b;
    logic [7:0] lvl_c;
    int cyc = 0, checks = 0, errors = 0;
    typedef struct {int cyc; int sel; int lvl; int bsy; int at; int pwm; string name;} exp_t;
    exp_t sb[$];

    lcd_backlight_fader #(.PWM_BITS(4), .MAX_LEVEL(15), .STEP_CYCLES(4)) u_a (
        .clk(clk), .reset(reset), .light_req(light_a), .fade_en(fade_a),
        .lcd_bl_pwm(pwm_a), .level(lvl_a), .busy(busy_a), .at_target(at_a));
    lcd_backlight_fader #(.PWM_BITS(4), .MAX_LEVEL(5), .STEP_CYCLES(4)) u_b (
        .clk(clk), .reset(reset), .light_req(light_b), .fade_en(fade_b),
        .lcd_bl_pwm(pwm_b), .level(lvl_b), .busy(busy_b), .at_target(at_b));
    lcd_backlight_fader u_c (
        .clk(clk), .reset(reset), .light_req(light_c), .fade_en(fade_c),
        .lcd_bl_pwm(pwm_c), .level(lvl_c), .busy(busy_c), .at_target(at_c));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input int sel, input int dc, input int lvl, input int bsy, input int at, input int pwm, input string name);
        sb.push_back('{cyc + dc, sel, lvl, bsy, at, pwm, name});
    endtask

    task automatic check(input exp_t e);
        int al, ab, aa, ap;
        al = e.sel == 0 ? int'(lvl_a) : e.sel == 1 ? int'(lvl_b) : int'(lvl_c);
        ab = e.sel == 0 ? int'(busy_a) : e.sel == 1 ? int'(busy_b) : int'(busy_c);
        aa = e.sel == 0 ? int'(at_a) : e.sel == 1 ? int'(at_b) : int'(at_c);
        ap = e.sel == 0 ? int'(pwm_a) : e.sel == 1 ? int'(pwm_b) : int'(pwm_c);
        checks++;
        if (e.cyc != cyc || al != e.lvl || ab != e.bsy || aa != e.at || (e.pwm >= 0 && ap != e.pwm)) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d(want %0d) level %0d want %0d busy %0d want %0d at_target %0d want %0d pwm %0d want %0d",
                     e.name, e.sel, cyc, e.cyc, al, e.lvl, ab, e.bsy, aa, e.at, ap, e.pwm);
        end
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].cyc <= cyc) begin
                check(sb[i]);
                sb.delete(i);
            end
    end

    initial begin
        step(1);
        for (int s = 0; s < 3; s++) push_exp(s, 0, 0, 0, 1, 0, "reset");
        reset = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            push_exp(2, 0, 0, 0, 1, 0, "idle");
            step(1);
        end
        // pwm_cnt has run freely since the reset at edge 1, so after edge n it was (n-2)%15 on the previous edge
        light_b = 1'b1;
        for (int d = 3; d < 48; d++) push_exp(1, d, 5, 0, 1, ((cyc + d - 2) % 15) < 5 ? 1 : 0, "duty");
        step(50);
        light_a = 1'b1;
        push_exp(0, 1, 0, 0, 0, -1, "req_e0");
        push_exp(0, 2, 0, 1, 0, -1, "ramp_e1");
        for (int j = 1; j <= 15; j++) begin
            push_exp(0, 2 + 4*j - 1, j - 1, 1, 0, -1, "ramp_hold");
            push_exp(0, 2 + 4*j, j, j == 15 ? 0 : 1, j == 15 ? 1 : 0, -1, "ramp_step");
        end
        for (int d = 63; d <= 80; d++) push_exp(0, d, 15, 0, 1, 1, "on_pwm");
        step(85);
        fade_a = 1'b0;
        light_a = 1'b0;
        push_exp(0, 1, 15, 0, 0, -1, "byp_hold");
        push_exp(0, 2, 0, 0, 1, -1, "byp_off");
        for (int d = 3; d <= 8; d++) push_exp(0, d, 0, 0, 1, 0, "byp_off_idle");
        step(10);
        light_a = 1'b1;
        push_exp(0, 1, 0, 0, 0, -1, "byp_req");
        push_exp(0, 2, 15, 0, 1, -1, "byp_on");
        for (int d = 3; d <= 10; d++) push_exp(0, d, 15, 0, 1, 1, "byp_on_idle");
        step(12);
        light_a = 1'b0;
        push_exp(0, 2, 0, 0, 1, -1, "byp_off2");
        step(4);
        fade_a = 1'b1;
        step(2);
        light_a = 1'b1;
        push_exp(0, 26, 6, 1, 0, -1, "rev_pre");
        step(26);
        light_a = 1'b0;
        push_exp(0, 1, 6, 1, 0, -1, "rev_e0");
        for (int j = 0; j < 4; j++) push_exp(0, 2 + j, 6, 1, 0, -1, "rev_hold");
        for (int j = 1; j <= 6; j++) begin
            if (j > 1) push_exp(0, 2 + 4*j - 1, 7 - j, 1, 0, -1, "rev_pre_step");
            push_exp(0, 2 + 4*j, 6 - j, j == 6 ? 0 : 1, j == 6 ? 1 : 0, -1, "rev_step");
        end
        for (int d = 27; d <= 32; d++) push_exp(0, d, 0, 0, 1, 0, "rev_off");
        step(35);
        light_a = 1'b1;
        step(38);
        push_exp(0, 0, 9, 1, 0, -1, "mid_lvl9");
        reset = 1'b1;
        push_exp(0, 1, 0, 0, 1, 0, "mid_reset");
        step(1);
        reset = 1'b0;
        push_exp(0, 1, 0, 0, 0, -1, "restart_e0");
        push_exp(0, 2, 0, 1, 0, -1, "restart_e1");
        push_exp(0, 5, 0, 1, 0, -1, "restart_hold");
        push_exp(0, 6, 1, 1, 0, -1, "restart_step");
        step(10);
        foreach (sb[i]) begin
            errors++;
            $display("FAIL pending %s dut%0d never compared at cyc %0d", sb[i].name, sb[i].sel, sb[i].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
